// File: rtl/harmonic_frame_loader.sv
// Serial-to-parallel loader: packs four complex samples into a shadow bank,
// then commits them atomically to four registered constellation points.
module harmonic_frame_loader #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WORD_SIZE-1:0] i_harmonic_re,
  input  logic [WORD_SIZE-1:0] i_harmonic_im,
  input  logic                 i_hold,
  input  logic                 i_restart,
  output logic [1:0]           o_slot,
  output logic [WORD_SIZE-1:0] o_constellation_point1_re,
  output logic [WORD_SIZE-1:0] o_constellation_point1_im,
  output logic [WORD_SIZE-1:0] o_constellation_point2_re,
  output logic [WORD_SIZE-1:0] o_constellation_point2_im,
  output logic [WORD_SIZE-1:0] o_constellation_point3_re,
  output logic [WORD_SIZE-1:0] o_constellation_point3_im,
  output logic [WORD_SIZE-1:0] o_constellation_point4_re,
  output logic [WORD_SIZE-1:0] o_constellation_point4_im,
  output logic                 o_frame_valid
);

  typedef enum logic {FILL, COMMIT} state_e;
  typedef logic [WORD_SIZE-1:0] word_t;

  state_e     state_q, state_d;
  logic [1:0] slot_q, slot_d;
  logic       frame_valid_q, frame_valid_d;
  word_t      shadow_re_q [4];
  word_t      shadow_re_d [4];
  word_t      shadow_im_q [4];
  word_t      shadow_im_d [4];
  word_t      bank_re_q   [4];
  word_t      bank_re_d   [4];
  word_t      bank_im_q   [4];
  word_t      bank_im_d   [4];
  logic       accept;

  // COMMIT blocks intake for its single cycle so the shadow bank is stable while copied.
  assign o_ready = i_rst_n && (state_q == FILL) && !i_hold;
  assign accept  = i_valid && o_ready;

  // NOTE: every _d gets a default from its _q first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    frame_valid_d = 1'b0;
    shadow_re_d   = shadow_re_q;
    shadow_im_d   = shadow_im_q;
    bank_re_d     = bank_re_q;
    bank_im_d     = bank_im_q;
    unique case (state_q)
      FILL: begin
        if (i_restart) begin
          slot_d = 2'd0;
        end else if (accept) begin
          shadow_re_d[slot_q] = i_harmonic_re;
          shadow_im_d[slot_q] = i_harmonic_im;
          slot_d              = slot_q + 2'd1;
          if (slot_q == 2'd3) state_d = COMMIT;
        end
      end
      COMMIT: begin
        bank_re_d     = shadow_re_q;
        bank_im_d     = shadow_im_q;
        frame_valid_d = 1'b1;
        state_d       = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: the shadow and committed banks are reset too, because downstream must read zeros after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= FILL;
      slot_q        <= 2'd0;
      frame_valid_q <= 1'b0;
      shadow_re_q   <= '{default: '0};
      shadow_im_q   <= '{default: '0};
      bank_re_q     <= '{default: '0};
      bank_im_q     <= '{default: '0};
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      frame_valid_q <= frame_valid_d;
      shadow_re_q   <= shadow_re_d;
      shadow_im_q   <= shadow_im_d;
      bank_re_q     <= bank_re_d;
      bank_im_q     <= bank_im_d;
    end
  end

  assign o_slot                    = slot_q;
  assign o_frame_valid             = frame_valid_q;
  assign o_constellation_point1_re = bank_re_q[0];
  assign o_constellation_point1_im = bank_im_q[0];
  assign o_constellation_point2_re = bank_re_q[1];
  assign o_constellation_point2_im = bank_im_q[1];
  assign o_constellation_point3_re = bank_re_q[2];
  assign o_constellation_point3_im = bank_im_q[2];
  assign o_constellation_point4_re = bank_re_q[3];
  assign o_constellation_point4_im = bank_im_q[3];

endmodule

// File: doc/harmonic_frame_loader.md
# harmonic_frame_loader

- Write-side counterpart to the harmonic selector.
- Accepts a serial stream of complex harmonic samples over a valid/ready handshake. Packs each group of four into a shadow bank, then commits the group atomically to four parallel constellation-point output registers.
- Sits between a serial symbol source (demodulator or test pattern generator) and any logic that indexes the four points by a 2-bit select.
- Double-buffered, so downstream always sees a complete, consistent set of four points.

## Interface
- WORD_SIZE, 16, width of each real/imaginary component (two's complement, passed through unmodified)
- i_clk  input  1  rising-edge clock, single clock domain
- i_rst_n  input  1  synchronous, active-low reset
- i_valid  input  1  sample present on i_harmonic_re/im
- o_ready  output  1  block can accept a sample this cycle
- i_harmonic_re  input  WORD_SIZE  real part of incoming sample
- i_harmonic_im  input  WORD_SIZE  imaginary part of incoming sample
- i_hold  input  1  downstream backpressure; forces o_ready low
- i_restart  input  1  abort partial frame; next accepted sample goes to slot 0
- o_slot  output  2  index of slot the next accepted sample will fill
- o_constellation_point1_re/_im … o_constellation_point4_re/_im  output  WORD_SIZE each  committed bank, slots 0..3
- o_frame_valid  output  1  one-cycle pulse: committed bank just updated

## Operation
- Accept event: i_valid && o_ready at a rising edge. No sample is ever written without it.
- States: FILL, COMMIT.
- FILL
  - o_ready = !i_hold.
  - Accept writes the sample into shadow slot o_slot, and o_slot increments.
  - An accept with o_slot==3 writes shadow slot 3, wraps o_slot to 0 and moves to COMMIT.
- COMMIT (exactly one cycle)
  - o_ready = 0 regardless of i_valid and i_hold.
  - At the closing edge: all four shadow slots are copied to the committed bank, o_frame_valid is registered high for the following cycle, and the state returns to FILL.
- Committed bank changes only at a commit edge. Between commits its outputs are stable.
- i_restart (synchronous, sampled every edge)
  - In FILL: o_slot←0 and shadow contents are don't-care. Restart has priority over a simultaneous accept: that sample is dropped, even though o_ready was high.
  - In COMMIT: ignored. The commit completes and the next frame starts at slot 0 anyway.
  - Committed bank and o_frame_valid are never affected by i_restart.
- i_hold does not abort a frame. Partial shadow contents and o_slot are retained indefinitely.
- No arithmetic on data. Widths are preserved bit-for-bit, with no sign extension or truncation.

## Timing
- Reset (i_rst_n low at an edge):
  - state←FILL, o_slot←0, o_frame_valid←0.
  - All committed and shadow registers←0.
  - o_ready is 0 while i_rst_n is low. After release it follows the FILL rule.
- Reset mid-frame or during COMMIT discards everything, including a pending commit.
- Latency: 4th sample accepted at edge k. COMMIT is the cycle k..k+1. The committed bank and o_frame_valid=1 are visible after edge k+1, and o_frame_valid drops after edge k+2.
- Peak throughput: 4 samples per 5 cycles. Back-to-back frames with i_valid held high give o_frame_valid every 5th cycle.
- o_ready is combinational from state, i_hold and i_rst_n only. It never depends on i_valid.
- o_slot is registered and updates at the accept edge.

## Test plan
- Reset then stream 1+1j, 2+2j, 3+3j, 4+4j (re=im=0x0001..0x0004) with i_valid held high.
  - o_ready drops for exactly one cycle after the 4th accept.
  - Points 1..4 read 0x0001..0x0004, and o_frame_valid pulses once, one cycle after COMMIT.
- Two frames back-to-back (0x0010..0x0013, then 0x0020..0x0023).
  - o_frame_valid pulses 5 cycles apart.
  - Bank shows frame 1 unchanged until the second commit edge, then frame 2.
- Accept slots 0,1 (0x00A0, 0x00A1), then assert i_hold for 10 cycles with i_valid high.
  - o_ready=0 throughout, and o_slot stays 2.
  - After release, two more samples 0x00A2, 0x00A3 commit as points 1..4 = 0x00A0..0x00A3.
- Accept 3 samples, then i_restart together with i_valid carrying 0x7FFF.
  - 0x7FFF is dropped and o_slot=0.
  - Next 4 samples 0x8000..0x8003 commit, with the negative values preserved exactly.
  - The bank from the prior frame is unchanged until then.
- Pull i_rst_n low during COMMIT.
  - No o_frame_valid pulse, all points read 0, o_slot=0.
  - o_ready=0 while reset is low and =1 on the first cycle after release.
